// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - MSB-first square-and-multiply sequencer over the shared 16/8 divider
// Each step issues an 8x8 product as dividend and keeps the 8-bit remainder as the accumulator.
module modexp_ctrl #(
   parameter int EXP_W       = 8,
   parameter int DIV_TIMEOUT = 31
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       base,
   input  logic [EXP_W-1:0] exponent,
   input  logic [7:0]       modulus,
   output logic             busy,
   output logic             done,
   output logic [7:0]       result,
   output logic             error,
   output logic             div_start,
   output logic [15:0]      div_x,
   output logic [7:0]       div_y,
   input  logic             div_done,
   input  logic [15:0]      div_rem
);

   localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_SQ_ISSUE  = 3'd2;
   localparam logic [2:0] S_SQ_WAIT   = 3'd3;
   localparam logic [2:0] S_MUL_ISSUE = 3'd4;
   localparam logic [2:0] S_MUL_WAIT  = 3'd5;
   localparam logic [2:0] S_NEXT      = 3'd6;
   localparam logic [2:0] S_FIN       = 3'd7;

   logic [2:0]       state;
   logic [7:0]       base_r;
   logic [EXP_W-1:0] exp_r;
   logic [7:0]       acc;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic             unused_rem;

   assign unused_rem = ^div_rem[15:8];

   function automatic logic [15:0] mul8(input logic [7:0] a, input logic [7:0] b);
      return 16'(a) * 16'(b);
   endfunction

   assign busy = (state != S_IDLE);
   assign done = (state == S_FIN);

   // div_start and div_x are loaded on entry to an ISSUE state so the pulse
   // and its dividend appear together during the ISSUE cycle itself.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         base_r    <= '0;
         exp_r     <= '0;
         acc       <= '0;
         idx       <= '0;
         cnt       <= '0;
         error     <= 1'b0;
         result    <= '0;
         div_start <= 1'b0;
         div_x     <= '0;
         div_y     <= '0;
      end else begin
         div_start <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  base_r <= base;
                  exp_r  <= exponent;
                  div_y  <= modulus;
                  error  <= 1'b0;
                  state  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (div_y == 8'd0) begin
                  error  <= 1'b1;
                  result <= '0;
                  state  <= S_FIN;
               end else if (div_y == 8'd1) begin
                  result <= '0;
                  state  <= S_FIN;
               end else begin
                  acc       <= 8'd1;
                  idx       <= IDX_W'(EXP_W - 1);
                  div_x     <= 16'd1;
                  div_start <= 1'b1;
                  cnt       <= '0;
                  state     <= S_SQ_ISSUE;
               end
            end
            S_SQ_ISSUE:  state <= S_SQ_WAIT;
            S_MUL_ISSUE: state <= S_MUL_WAIT;
            S_SQ_WAIT, S_MUL_WAIT: begin
               if (div_done) begin
                  acc <= div_rem[7:0];
                  if (state == S_SQ_WAIT && exp_r[idx]) begin
                     div_x     <= mul8(div_rem[7:0], base_r);
                     div_start <= 1'b1;
                     cnt       <= '0;
                     state     <= S_MUL_ISSUE;
                  end else begin
                     state <= S_NEXT;
                  end
               end else if (cnt == CNT_W'(DIV_TIMEOUT - 1)) begin
                  error  <= 1'b1;
                  result <= '0;
                  state  <= S_FIN;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_NEXT: begin
               if (idx == '0) begin
                  result <= acc;
                  state  <= S_FIN;
               end else begin
                  idx       <= idx - 1'b1;
                  div_x     <= mul8(acc, acc);
                  div_start <= 1'b1;
                  cnt       <= '0;
                  state     <= S_SQ_ISSUE;
               end
            end
            S_FIN:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
